// File: rtl/risc_toy_pipe5.sv
// Five-stage toy RISC pipeline (IF/ID/EX/MEM/WB); define RISC_TOY_FWD_EN for EX operand forwarding.
// One instruction per cycle; hazards stall PC and IF/ID and insert EX bubbles; taken branches flush two slots.
module risc_toy_pipe5 #(
    parameter int                XLEN     = 32,
    parameter int                ADDR_W   = 16,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [31:0]       imem_rdata,
    output logic              dmem_en,
    output logic              dmem_we,
    output logic [ADDR_W-1:0] dmem_addr,
    output logic [XLEN-1:0]   dmem_wdata,
    input  logic [XLEN-1:0]   dmem_rdata,
    output logic              halted,
    output logic [31:0]       retire_cnt
);

    localparam logic [4:0] OP_ADD  = 5'd1;
    localparam logic [4:0] OP_SUB  = 5'd2;
    localparam logic [4:0] OP_NEG  = 5'd3;
    localparam logic [4:0] OP_AND  = 5'd4;
    localparam logic [4:0] OP_OR   = 5'd5;
    localparam logic [4:0] OP_XOR  = 5'd6;
    localparam logic [4:0] OP_ADDI = 5'd7;
    localparam logic [4:0] OP_LDR  = 5'd8;
    localparam logic [4:0] OP_STR  = 5'd9;
    localparam logic [4:0] OP_BZ   = 5'd10;
    localparam logic [4:0] OP_J    = 5'd11;
    localparam logic [4:0] OP_JL   = 5'd12;
    localparam logic [4:0] OP_HALT = 5'd31;

    function automatic logic reads_rs1(input logic [4:0] op);
        return (op >= OP_ADD) && (op <= OP_BZ);
    endfunction

    // STR's second source is its rd field (the store data).
    function automatic logic reads_src2(input logic [4:0] op);
        return op inside {OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_STR};
    endfunction

    function automatic logic writes_rd(input logic [4:0] op);
        return ((op >= OP_ADD) && (op <= OP_LDR)) || (op == OP_JL);
    endfunction

    // IF
    logic [ADDR_W-1:0] pc;
    logic              stopping;

    // IF/ID
    logic              if_id_vld;
    logic [31:0]       if_id_ins;
    logic [ADDR_W-1:0] if_id_pc;

    // ID/EX
    logic              id_ex_vld;
    logic [4:0]        id_ex_op;
    logic [4:0]        id_ex_rd;
    logic              id_ex_we;
    logic [XLEN-1:0]   id_ex_a;
    logic [XLEN-1:0]   id_ex_b;
    logic [16:0]       id_ex_imm;
    logic [ADDR_W-1:0] id_ex_pc;
`ifdef RISC_TOY_FWD_EN
    logic [4:0]        id_ex_rs1;
    logic [4:0]        id_ex_src2;
`endif

    // EX/MEM
    logic              ex_mem_vld;
    logic [4:0]        ex_mem_op;
    logic [4:0]        ex_mem_rd;
    logic              ex_mem_we;
    logic [XLEN-1:0]   ex_mem_res;
    logic [XLEN-1:0]   ex_mem_sdat;

    // MEM/WB
    logic              mem_wb_vld;
    logic [4:0]        mem_wb_rd;
    logic              mem_wb_we;
    logic              mem_wb_halt;
    logic [XLEN-1:0]   mem_wb_dat;

    logic [XLEN-1:0]   rf [32];

    // ID decode
    logic [4:0]        id_op, id_rd, id_rs1, id_src2;
    logic              id_use1, id_use2, id_halt;
    logic [XLEN-1:0]   id_a, id_b;
    logic              wb_wr;

    assign id_op   = if_id_ins[31:27];
    assign id_rd   = if_id_ins[26:22];
    assign id_rs1  = if_id_ins[21:17];
    assign id_src2 = (id_op == OP_STR) ? id_rd : if_id_ins[16:12];
    assign id_use1 = reads_rs1(id_op);
    assign id_use2 = reads_src2(id_op);
    assign id_halt = if_id_vld && (id_op == OP_HALT);
    assign wb_wr   = mem_wb_vld && mem_wb_we && (mem_wb_rd != 5'd0);

    // Register read with write-through from the instruction retiring this cycle.
    always_comb begin
        id_a = '0;
        id_b = '0;
        if (id_rs1 != 5'd0)
            id_a = (wb_wr && (mem_wb_rd == id_rs1)) ? mem_wb_dat : rf[id_rs1];
        if (id_src2 != 5'd0)
            id_b = (wb_wr && (mem_wb_rd == id_src2)) ? mem_wb_dat : rf[id_src2];
    end

    // Hazard detection against producers still in flight
    logic ex_dep, stall;

    assign ex_dep = id_ex_vld && id_ex_we && (id_ex_rd != 5'd0) &&
                    ((id_use1 && (id_rs1 == id_ex_rd)) || (id_use2 && (id_src2 == id_ex_rd)));

`ifdef RISC_TOY_FWD_EN
    assign stall = if_id_vld && ex_dep && (id_ex_op == OP_LDR);
`else
    logic mem_dep;

    assign mem_dep = ex_mem_vld && ex_mem_we && (ex_mem_rd != 5'd0) &&
                     ((id_use1 && (id_rs1 == ex_mem_rd)) || (id_use2 && (id_src2 == ex_mem_rd)));
    assign stall   = if_id_vld && (ex_dep || mem_dep);
`endif

    // EX operands
    logic [XLEN-1:0] ex_a, ex_b;

    always_comb begin
        ex_a = id_ex_a;
        ex_b = id_ex_b;
`ifdef RISC_TOY_FWD_EN
        if (ex_mem_vld && ex_mem_we && (ex_mem_rd != 5'd0) && (ex_mem_rd == id_ex_rs1))
            ex_a = ex_mem_res;
        else if (wb_wr && (mem_wb_rd == id_ex_rs1))
            ex_a = mem_wb_dat;
        if (ex_mem_vld && ex_mem_we && (ex_mem_rd != 5'd0) && (ex_mem_rd == id_ex_src2))
            ex_b = ex_mem_res;
        else if (wb_wr && (mem_wb_rd == id_ex_src2))
            ex_b = mem_wb_dat;
`endif
    end

    // EX: ALU and branch resolution; NEG negates rs1.
    logic [XLEN-1:0]   imm_x, ex_res;
    logic [ADDR_W-1:0] br_tgt;
    logic              ex_taken, flush;

    assign imm_x  = XLEN'($signed(id_ex_imm));
    assign br_tgt = id_ex_pc + ADDR_W'($signed({id_ex_imm, 2'b00}));

    always_comb begin
        ex_res   = '0;
        ex_taken = 1'b0;
        case (id_ex_op)
            OP_ADD:                  ex_res = ex_a + ex_b;
            OP_SUB:                  ex_res = ex_a - ex_b;
            OP_NEG:                  ex_res = '0 - ex_a;
            OP_AND:                  ex_res = ex_a & ex_b;
            OP_OR:                   ex_res = ex_a | ex_b;
            OP_XOR:                  ex_res = ex_a ^ ex_b;
            OP_ADDI, OP_LDR, OP_STR: ex_res = ex_a + imm_x;
            OP_BZ:                   ex_taken = (ex_a == '0);
            OP_J:                    ex_taken = 1'b1;
            OP_JL: begin
                ex_taken = 1'b1;
                ex_res   = XLEN'(id_ex_pc + ADDR_W'(4));
            end
            default: ;
        endcase
    end

    assign flush = id_ex_vld && ex_taken;

    // PC and IF/ID; a flush overrides any stall, HALT in ID stops fetch for good.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc        <= RESET_PC;
            stopping  <= 1'b0;
            if_id_vld <= 1'b0;
            if_id_ins <= '0;
            if_id_pc  <= '0;
        end else if (flush) begin
            pc        <= br_tgt;
            if_id_vld <= 1'b0;
        end else if (!stall) begin
            if (id_halt || stopping) begin
                if_id_vld <= 1'b0;
                if (id_halt)
                    stopping <= 1'b1;
            end else begin
                pc        <= pc + ADDR_W'(4);
                if_id_vld <= 1'b1;
                if_id_ins <= imem_rdata;
                if_id_pc  <= pc;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            id_ex_vld  <= 1'b0;
            id_ex_op   <= '0;
            id_ex_rd   <= '0;
            id_ex_we   <= 1'b0;
            id_ex_a    <= '0;
            id_ex_b    <= '0;
            id_ex_imm  <= '0;
            id_ex_pc   <= '0;
`ifdef RISC_TOY_FWD_EN
            id_ex_rs1  <= '0;
            id_ex_src2 <= '0;
`endif
        end else begin
            id_ex_vld  <= if_id_vld && !flush && !stall;
            id_ex_op   <= id_op;
            id_ex_rd   <= id_rd;
            id_ex_we   <= writes_rd(id_op);
            id_ex_a    <= id_a;
            id_ex_b    <= id_b;
            id_ex_imm  <= if_id_ins[16:0];
            id_ex_pc   <= if_id_pc;
`ifdef RISC_TOY_FWD_EN
            id_ex_rs1  <= id_rs1;
            id_ex_src2 <= id_src2;
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_mem_vld  <= 1'b0;
            ex_mem_op   <= '0;
            ex_mem_rd   <= '0;
            ex_mem_we   <= 1'b0;
            ex_mem_res  <= '0;
            ex_mem_sdat <= '0;
        end else begin
            ex_mem_vld  <= id_ex_vld;
            ex_mem_op   <= id_ex_op;
            ex_mem_rd   <= id_ex_rd;
            ex_mem_we   <= id_ex_we;
            ex_mem_res  <= ex_res;
            ex_mem_sdat <= ex_b;
        end
    end

    // MEM
    assign dmem_en    = ex_mem_vld && ((ex_mem_op == OP_LDR) || (ex_mem_op == OP_STR));
    assign dmem_we    = ex_mem_vld && (ex_mem_op == OP_STR);
    assign dmem_addr  = ADDR_W'(ex_mem_res);
    assign dmem_wdata = ex_mem_sdat;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_wb_vld  <= 1'b0;
            mem_wb_rd   <= '0;
            mem_wb_we   <= 1'b0;
            mem_wb_halt <= 1'b0;
            mem_wb_dat  <= '0;
        end else begin
            mem_wb_vld  <= ex_mem_vld;
            mem_wb_rd   <= ex_mem_rd;
            mem_wb_we   <= ex_mem_we;
            mem_wb_halt <= (ex_mem_op == OP_HALT);
            mem_wb_dat  <= (ex_mem_op == OP_LDR) ? dmem_rdata : ex_mem_res;
        end
    end

    // WB
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 32; i++)
                rf[i] <= '0;
        end else if (wb_wr) begin
            rf[mem_wb_rd] <= mem_wb_dat;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            halted     <= 1'b0;
            retire_cnt <= '0;
        end else if (mem_wb_vld) begin
            retire_cnt <= retire_cnt + 32'd1;
            if (mem_wb_halt)
                halted <= 1'b1;
        end
    end

    assign imem_addr = pc;

endmodule

// File: tb/tb_risc_toy_pipe5.sv
// Bench for risc_toy_pipe5: directed programs plus random programs checked against an instruction-level model.
module tb_risc_toy_pipe5;

    localparam logic [15:0] RESET_PC = 16'h0000;
    localparam logic [31:0] HALT_I   = 32'hF800_0000;
`ifdef RISC_TOY_FWD_EN
    localparam int STALL_RAW = 0;
    localparam int STALL_LDU = 1;
`else
    localparam int STALL_RAW = 2;
    localparam int STALL_LDU = 2;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [15:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        dmem_en, dmem_we;
    logic [15:0] dmem_addr;
    logic [31:0] dmem_wdata, dmem_rdata;
    logic        halted;
    logic [31:0] retire_cnt;

    int n_pass = 0;
    int n_fail = 0;
    int n_total = 0;

    logic [31:0] imem [256];
    logic [31:0] dmem [256];
    logic        clr_mem = 1'b1;
    logic [15:0] st_addr_q [$];
    logic [31:0] st_dat_q [$];
    logic [15:0] exp_addr_q [$];
    logic [31:0] exp_dat_q [$];
    int          exp_ret;

    always #5 clk = ~clk;

    risc_toy_pipe5 #(.XLEN(32), .ADDR_W(16), .RESET_PC(RESET_PC)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .imem_addr  (imem_addr),
        .imem_rdata (imem_rdata),
        .dmem_en    (dmem_en),
        .dmem_we    (dmem_we),
        .dmem_addr  (dmem_addr),
        .dmem_wdata (dmem_wdata),
        .dmem_rdata (dmem_rdata),
        .halted     (halted),
        .retire_cnt (retire_cnt)
    );

    assign imem_rdata = imem[imem_addr[9:2]];
    assign dmem_rdata = dmem[dmem_addr[9:2]];

    always @(posedge clk) begin
        if (clr_mem) begin
            for (int i = 0; i < 256; i++) dmem[i] <= '0;
            st_addr_q.delete();
            st_dat_q.delete();
        end else if (dmem_en && dmem_we) begin
            dmem[dmem_addr[9:2]] <= dmem_wdata;
            st_addr_q.push_back(dmem_addr);
            st_dat_q.push_back(dmem_wdata);
        end
    end

    function automatic logic [31:0] r_t(input logic [4:0] op, rd, rs1, rs2);
        return {op, rd, rs1, rs2, 12'd0};
    endfunction

    function automatic logic [31:0] i_t(input logic [4:0] op, rd, rs1, input logic [16:0] imm);
        return {op, rd, rs1, imm};
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_imem();
        for (int i = 0; i < 256; i++) imem[i] = '0;
    endtask

    // Sequential instruction-at-a-time interpreter: expected stores and retire count.
    task automatic iss();
        logic [31:0] r [32];
        logic [31:0] m [256];
        logic [15:0] pc, nxt;
        logic [31:0] ins, a, b, imm, ea;
        logic [4:0]  op, rd;
        bit          done;
        for (int i = 0; i < 32; i++) r[i] = '0;
        for (int i = 0; i < 256; i++) m[i] = '0;
        pc = RESET_PC;
        exp_ret = 0;
        exp_addr_q.delete();
        exp_dat_q.delete();
        done = 0;
        for (int step = 0; step < 5000 && !done; step++) begin
            ins = imem[pc[9:2]];
            op  = ins[31:27];
            rd  = ins[26:22];
            a   = r[ins[21:17]];
            b   = r[ins[16:12]];
            imm = {{15{ins[16]}}, ins[16:0]};
            ea  = a + imm;
            nxt = pc + 16'd4;
            exp_ret++;
            case (op)
                5'd1:  r[rd] = a + b;
                5'd2:  r[rd] = a - b;
                5'd3:  r[rd] = 32'd0 - a;
                5'd4:  r[rd] = a & b;
                5'd5:  r[rd] = a | b;
                5'd6:  r[rd] = a ^ b;
                5'd7:  r[rd] = ea;
                5'd8:  r[rd] = m[ea[9:2]];
                5'd9: begin
                    m[ea[9:2]] = r[rd];
                    exp_addr_q.push_back(ea[15:0]);
                    exp_dat_q.push_back(r[rd]);
                end
                5'd10: if (a == 32'd0) nxt = pc + {imm[13:0], 2'b00};
                5'd11: nxt = pc + {imm[13:0], 2'b00};
                5'd12: begin
                    r[rd] = {16'd0, pc + 16'd4};
                    nxt   = pc + {imm[13:0], 2'b00};
                end
                5'd31: done = 1;
                default: ;
            endcase
            r[0] = '0;
            pc   = nxt;
        end
    endtask

    task automatic run_prog(output int cyc);
        rst_n   = 1'b0;
        clr_mem = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        clr_mem = 1'b0;
        rst_n   = 1'b1;
        cyc = 0;
        while (!halted && cyc < 3000) begin
            @(negedge clk);
            cyc++;
        end
        repeat (4) @(negedge clk);
    endtask

    task automatic run_and_check(input string tag, output int cyc);
        iss();
        run_prog(cyc);
        check({tag, " halted"}, halted, 1'b1);
        check({tag, " retire_cnt"}, retire_cnt, exp_ret);
        check({tag, " store_count"}, st_addr_q.size(), exp_addr_q.size());
        foreach (exp_addr_q[i]) begin
            if (i < st_addr_q.size()) begin
                check($sformatf("%s store%0d_addr", tag, i), st_addr_q[i], exp_addr_q[i]);
                check($sformatf("%s store%0d_data", tag, i), st_dat_q[i], exp_dat_q[i]);
            end
        end
    endtask

    task automatic gen_random(input int n);
        logic [4:0] rd, rs1, rs2;
        int k;
        clear_imem();
        for (int i = 0; i < n; i++) begin
            k   = int'($urandom_range(0, 11));
            rd  = 5'($urandom_range(0, 7));
            rs1 = 5'($urandom_range(0, 7));
            rs2 = 5'($urandom_range(0, 7));
            case (k)
                0, 1, 2, 3, 4, 5: imem[i] = r_t(5'($urandom_range(1, 6)), rd, rs1, rs2);
                6:  imem[i] = i_t(5'd7, rd, rs1, 17'($urandom));
                7:  imem[i] = i_t(5'd8, rd, 5'd0, 17'($urandom_range(0, 127) * 4));
                8:  imem[i] = i_t(5'd9, rd, 5'd0, 17'($urandom_range(0, 127) * 4));
                9:  imem[i] = (i < n - 3) ? i_t(5'd10, 5'd0, rs1, 17'($urandom_range(1, 3))) : 32'd0;
                10: imem[i] = (i < n - 3) ? i_t(5'($urandom_range(11, 12)), rd, 5'd0, 17'($urandom_range(1, 3))) : 32'd0;
                default: imem[i] = {5'($urandom_range(13, 30)), 27'($urandom)};
            endcase
        end
        for (int j = 1; j < 8; j++) imem[n + j - 1] = i_t(5'd9, 5'(j), 5'd0, 17'(32'h300 + 4 * j));
        imem[n + 7] = HALT_I;
    endtask

    initial begin
        int c_a, c_b, c_c, c_d, cyc, n16;

        // Reset values
        clear_imem();
        #1 rst_n = 1'b0;
        #10;
        check("reset imem_addr", imem_addr, RESET_PC);
        check("reset dmem_en", dmem_en, 1'b0);
        check("reset dmem_we", dmem_we, 1'b0);
        check("reset halted", halted, 1'b0);
        check("reset retire_cnt", retire_cnt, 32'd0);

        // Back-to-back RAW dependency vs. independent twin
        clear_imem();
        imem[0] = i_t(5'd7, 5'd1, 5'd0, 17'd5);
        imem[1] = r_t(5'd1, 5'd2, 5'd1, 5'd1);
        imem[2] = i_t(5'd9, 5'd2, 5'd0, 17'h100);
        imem[3] = HALT_I;
        run_and_check("raw_dep", c_a);
        check("raw r2 value", (st_dat_q.size() > 0) ? st_dat_q[0] : 32'd0, 32'd10);
        imem[1] = i_t(5'd7, 5'd2, 5'd0, 17'd10);
        run_and_check("raw_indep", c_b);
        check("raw stall cycles", c_a - c_b, STALL_RAW);

        // Store, load, load-use
        clear_imem();
        imem[0] = i_t(5'd7, 5'd2, 5'd0, 17'd10);
        imem[1] = i_t(5'd9, 5'd2, 5'd0, 17'd16);
        imem[2] = i_t(5'd8, 5'd3, 5'd0, 17'd16);
        imem[3] = r_t(5'd1, 5'd4, 5'd3, 5'd3);
        imem[4] = i_t(5'd9, 5'd4, 5'd0, 17'h104);
        imem[5] = HALT_I;
        run_and_check("ldu_dep", c_c);
        check("ldu r4 value", (st_dat_q.size() > 1) ? st_dat_q[1] : 32'd0, 32'd20);
        n16 = 0;
        foreach (st_addr_q[i]) if (st_addr_q[i] == 16'd16) n16++;
        check("ldu we cycles at 16", n16, 1);
        imem[3] = i_t(5'd7, 5'd4, 5'd0, 17'd20);
        run_and_check("ldu_indep", c_d);
        check("ldu bubble cycles", c_c - c_d, STALL_LDU);

        // Taken BZ flushes the two following ADDIs
        clear_imem();
        imem[0] = i_t(5'd10, 5'd0, 5'd0, 17'd3);
        imem[1] = i_t(5'd7, 5'd5, 5'd0, 17'd7);
        imem[2] = i_t(5'd7, 5'd5, 5'd0, 17'd9);
        imem[3] = i_t(5'd9, 5'd5, 5'd0, 17'h108);
        imem[4] = HALT_I;
        run_and_check("bz_flush", cyc);
        check("bz r5 value", (st_dat_q.size() > 0) ? st_dat_q[0] : 32'hdead, 32'd0);
        check("bz retired", retire_cnt, 32'd3);

        // JL at 0x20
        clear_imem();
        imem[8]  = i_t(5'd12, 5'd31, 5'd0, 17'd2);
        imem[9]  = i_t(5'd7, 5'd6, 5'd0, 17'd1);
        imem[10] = i_t(5'd9, 5'd31, 5'd0, 17'h10c);
        imem[11] = i_t(5'd9, 5'd6, 5'd0, 17'h110);
        imem[12] = HALT_I;
        run_and_check("jl", cyc);
        check("jl r31 value", (st_dat_q.size() > 0) ? st_dat_q[0] : 32'd0, 32'h24);
        check("jl r6 value", (st_dat_q.size() > 1) ? st_dat_q[1] : 32'hdead, 32'd0);
        check("jl retired", retire_cnt, 32'd12);

        // Six instructions then HALT; fetch stays frozen
        clear_imem();
        for (int i = 0; i < 6; i++) imem[i] = i_t(5'd7, 5'(i + 1), 5'd0, 17'(i + 1));
        imem[6] = HALT_I;
        run_and_check("halt", cyc);
        repeat (20) @(negedge clk);
        check("halt retire_cnt", retire_cnt, 32'd7);
        check("halt sticky", halted, 1'b1);
        check("halt imem_addr frozen", imem_addr, 16'h001c);

        // Random programs; the first is interrupted by a mid-run reset
        for (int p = 0; p < 3; p++) begin
            gen_random(24);
            if (p == 0) begin
                rst_n   = 1'b0;
                clr_mem = 1'b1;
                repeat (2) @(posedge clk);
                @(negedge clk);
                clr_mem = 1'b0;
                rst_n   = 1'b1;
                repeat (14) @(posedge clk);
                #2 rst_n = 1'b0;
                #1;
                check("midrst imem_addr", imem_addr, RESET_PC);
                check("midrst dmem_en", dmem_en, 1'b0);
                check("midrst dmem_we", dmem_we, 1'b0);
                check("midrst halted", halted, 1'b0);
                check("midrst retire_cnt", retire_cnt, 32'd0);
            end
            run_and_check($sformatf("rand%0d", p), cyc);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
